ntt_stage_sched: RTL and testbench

//  Address/stage sequencer for the poly unit NTT datapath. On start it walks all stages of an in-place

---
 rtl/ntt_stage_sched_if.sv | 36 +++
 rtl/ntt_stage_sched.sv | 180 ++++++++++++++++++
 tb/tb_ntt_stage_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ntt_stage_sched_if.sv
// ntt_stage_sched_if: control/address bundle between the NTT sequencer,
// its controller (master) and the butterfly/RAM side it drives.
interface ntt_stage_sched_if #(
  parameter int ADDWID = 7,
  parameter int STGWID = 3
);
  logic              start;
  logic              mode;
  logic              stall;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDWID-1:0] rd_addr_a;
  logic [ADDWID-1:0] rd_addr_b;
  logic [ADDWID-1:0] tw_addr;
  logic              bf_inv;
  logic [STGWID-1:0] stage;
  logic              wr_en;
  logic [ADDWID-1:0] wr_addr_a;
  logic [ADDWID-1:0] wr_addr_b;
  logic              scl_en;

  modport master (
    output start, mode, stall,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b,
    input  tw_addr, bf_inv, stage, wr_en,
    input  wr_addr_a, wr_addr_b, scl_en
  );

  modport slave (
    input  start, mode, stall,
    output busy, done, rd_en, rd_addr_a, rd_addr_b,
    output tw_addr, bf_inv, stage, wr_en,
    output wr_addr_a, wr_addr_b, scl_en
  );
endinterface

// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: in-place radix-2 NTT/INTT butterfly address sequencer.
// Define NTTSCHED_SCALE_EN to append an INTT scale pass.
module ntt_stage_sched #(
  parameter int ADDWID = 7,
  parameter int STGWID = 3,
  parameter int BFLAT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  ntt_stage_sched_if.slave bus
);
  localparam int CW = $clog2(BFLAT) + 1;
  localparam logic [ADDWID-1:0] HLAST = ADDWID'((1 << (ADDWID-1)) - 1);
  localparam logic [ADDWID-1:0] NLAST = ADDWID'((1 << ADDWID) - 1);
  localparam logic [STGWID-1:0] SLAST = STGWID'(ADDWID - 1);
  localparam logic [CW-1:0]     CLAST = CW'(BFLAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_SCALE, S_SDRAIN
  } st_t;

  st_t               r_st, w_st_nx;
  logic [ADDWID-1:0] r_j, w_j_nx;
  logic [STGWID-1:0] r_s, w_s_nx;
  logic [CW-1:0]     r_c, w_c_nx;
  logic              r_mode, w_mode_nx;
  logic              r_done, w_done_nx;
  logic              w_rd_en, w_in_scl, w_to_scl;
  logic [STGWID-1:0] w_ls;
  logic [STGWID:0]   w_sh;
  logic [ADDWID-1:0] w_len, w_g, w_k, w_a, w_b, w_tw;
  logic              r_dl_en [BFLAT];
  logic [ADDWID-1:0] r_dl_a  [BFLAT];
  logic [ADDWID-1:0] r_dl_b  [BFLAT];

  assign w_in_scl = (r_st == S_SCALE);

`ifdef NTTSCHED_SCALE_EN
  assign w_to_scl   = r_mode;
  assign bus.scl_en = w_in_scl && w_rd_en;
`else
  assign w_to_scl   = 1'b0;
  assign bus.scl_en = 1'b0;
`endif

  // ls = log2(len): NTT halves the span per stage, INTT doubles it
  always_comb begin
    w_ls  = r_mode ? r_s : SLAST - r_s;
    w_sh  = {1'b0, w_ls} + (STGWID+1)'(1);
    w_len = ADDWID'(1) << w_ls;
    w_g   = r_j >> w_ls;
    w_k   = r_j & (w_len - ADDWID'(1));
    w_a   = (w_g << w_sh) | w_k;
    w_b   = w_a + w_len;
    w_tw  = (ADDWID'(1) << (r_mode ? SLAST - r_s : r_s)) + w_g;
  end

  always_comb begin
    w_st_nx   = r_st;
    w_j_nx    = r_j;
    w_s_nx    = r_s;
    w_c_nx    = r_c;
    w_mode_nx = r_mode;
    w_done_nx = 1'b0;
    w_rd_en   = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        if (bus.start && !r_done) begin
          w_st_nx   = S_ISSUE;
          w_mode_nx = bus.mode;
          w_j_nx    = '0;
          w_s_nx    = '0;
          w_c_nx    = '0;
        end
      end
      S_ISSUE: begin
        if (!bus.stall) begin
          w_rd_en = 1'b1;
          if (r_j == HLAST) begin
            w_st_nx = S_DRAIN;
            w_j_nx  = '0;
            w_c_nx  = '0;
          end else begin
            w_j_nx = r_j + ADDWID'(1);
          end
        end
      end
      S_DRAIN: begin
        if (r_c != CLAST) begin
          w_c_nx = r_c + CW'(1);
        end else if (r_s != SLAST) begin
          w_st_nx = S_ISSUE;
          w_s_nx  = r_s + STGWID'(1);
          w_c_nx  = '0;
        end else if (w_to_scl) begin
          w_st_nx = S_SCALE;
          w_c_nx  = '0;
        end else begin
          w_st_nx   = S_IDLE;
          w_s_nx    = '0;
          w_c_nx    = '0;
          w_done_nx = 1'b1;
        end
      end
      S_SCALE: begin
        if (!bus.stall) begin
          w_rd_en = 1'b1;
          if (r_j == NLAST) begin
            w_st_nx = S_SDRAIN;
            w_j_nx  = '0;
            w_c_nx  = '0;
          end else begin
            w_j_nx = r_j + ADDWID'(1);
          end
        end
      end
      S_SDRAIN: begin
        if (r_c != CLAST) begin
          w_c_nx = r_c + CW'(1);
        end else begin
          w_st_nx   = S_IDLE;
          w_s_nx    = '0;
          w_c_nx    = '0;
          w_done_nx = 1'b1;
        end
      end
      default: w_st_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_st   <= S_IDLE;
      r_j    <= '0;
      r_s    <= '0;
      r_c    <= '0;
      r_mode <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_st   <= w_st_nx;
      r_j    <= w_j_nx;
      r_s    <= w_s_nx;
      r_c    <= w_c_nx;
      r_mode <= w_mode_nx;
      r_done <= w_done_nx;
    end
  end

  // write-back pipe never freezes; stall bubbles flow through as wr_en=0
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BFLAT; i++) begin
        r_dl_en[i] <= 1'b0;
        r_dl_a[i]  <= '0;
        r_dl_b[i]  <= '0;
      end
    end else begin
      r_dl_en[0] <= w_rd_en;
      r_dl_a[0]  <= bus.rd_addr_a;
      r_dl_b[0]  <= bus.rd_addr_b;
      for (int i = 1; i < BFLAT; i++) begin
        r_dl_en[i] <= r_dl_en[i-1];
        r_dl_a[i]  <= r_dl_a[i-1];
        r_dl_b[i]  <= r_dl_b[i-1];
      end
    end
  end

  assign bus.busy      = (r_st != S_IDLE);
  assign bus.done      = r_done;
  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr_a = !w_rd_en ? '0 : (w_in_scl ? r_j : w_a);
  assign bus.rd_addr_b = !w_rd_en ? '0 : (w_in_scl ? r_j : w_b);
  assign bus.tw_addr   = (w_rd_en && !w_in_scl) ? w_tw : '0;
  assign bus.bf_inv    = r_mode;
  assign bus.stage     = r_s;
  assign bus.wr_en     = r_dl_en[BFLAT-1];
  assign bus.wr_addr_a = r_dl_a[BFLAT-1];
  assign bus.wr_addr_b = r_dl_b[BFLAT-1];
endmodule

// File: tb/tb_ntt_stage_sched.sv
// tb_ntt_stage_sched: table of whole-transform runs checked against a
// formula model, plus hand-written reset and reset-abort sequences.
`timescale 1ns/1ps
module tb_ntt_stage_sched;
  localparam int AW = 7;
  localparam int SW = 3;
  localparam int BL = 4;
`ifdef NTTSCHED_SCALE_EN
  localparam int SCN = 128;
  localparam int SCD = 132;
`else
  localparam int SCN = 0;
  localparam int SCD = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ntt_stage_sched_if #(.ADDWID(AW), .STGWID(SW)) bif ();

  ntt_stage_sched #(.ADDWID(AW), .STGWID(SW), .BFLAT(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    bit mode;
    int slo, shi, dup, done, s1c, nwr, nscl;
    int f0, f6, l6, res;
  } vec_t;

  vec_t tv [4];
  int n_chk = 0;
  int n_pass = 0;
  int iss_en [1200];
  int iss_a  [1200];
  int iss_b  [1200];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int pk(input int a, input int b, input int t);
    return (a << 16) | (b << 8) | t;
  endfunction

  function automatic int osum();
    return int'(bif.busy) + int'(bif.done) + int'(bif.rd_en)
         + int'(bif.rd_addr_a) + int'(bif.rd_addr_b) + int'(bif.tw_addr)
         + int'(bif.bf_inv) + int'(bif.stage) + int'(bif.wr_en)
         + int'(bif.wr_addr_a) + int'(bif.wr_addr_b) + int'(bif.scl_en);
  endfunction

  initial begin
    vec_t v;
    int nrd, nwr, nscl, done_t, s1c, f0, f6, l6, res, b1;
    int aerr, werr, ierr, serr, stl_rd, cur_s, mj, sidx;
    int len, g, k, ea, eb, et, a, b, tw, p, busy200, early;

    tv[0] = '{1'b0, -1, -2, -1, 477, 69, 448, 0,
              pk(0, 64, 1), pk(0, 1, 64), pk(126, 127, 127), 0};
    tv[1] = '{1'b1, -1, -2, -1, 477 + SCD, 69, 448 + SCN, SCN,
              pk(0, 1, 64), pk(0, 64, 1), pk(63, 127, 1), 0};
    tv[2] = '{1'b0, 10, 12, -1, 480, 72, 448, 0,
              pk(0, 64, 1), pk(0, 1, 64), pk(126, 127, 127),
              pk(9, 73, 1)};
    tv[3] = '{1'b0, -1, -2, 100, 477, 69, 448, 0,
              pk(0, 64, 1), pk(0, 1, 64), pk(126, 127, 127), 0};

    bif.start = 1'b0;
    bif.mode  = 1'b0;
    bif.stall = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", osum(), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int n = 0; n < 4; n++) begin
      v = tv[n];
      nrd = 0; nwr = 0; nscl = 0; done_t = -1; s1c = -1;
      f0 = -1; f6 = -1; l6 = -1; res = 0; b1 = 0;
      aerr = 0; werr = 0; ierr = 0; serr = 0; stl_rd = 0;
      cur_s = -1; mj = 0; sidx = 0;
      for (int t = 0; t < 1200 && done_t < 0; t++) begin
        @(posedge clk); #1;
        bif.start = (t == 0) || (t == v.dup) || (t == v.done);
        bif.mode  = (t == 0) ? v.mode : !v.mode;
        bif.stall = (t >= v.slo) && (t <= v.shi);
        @(negedge clk);
        a  = int'(bif.rd_addr_a);
        b  = int'(bif.rd_addr_b);
        tw = int'(bif.tw_addr);
        p  = pk(a, b, tw);
        if (t == 1) b1 = int'(bif.busy);
        if (bif.rd_en && bif.scl_en) begin
          nscl++;
          if (a != sidx || b != sidx || tw != 0) serr++;
          sidx++;
        end else if (bif.rd_en) begin
          nrd++;
          if (int'(bif.stage) != cur_s) begin
            if (int'(bif.stage) != cur_s + 1) aerr++;
            if (cur_s >= 0 && mj != 64) aerr++;
            cur_s = int'(bif.stage);
            mj = 0;
            if (cur_s == 1) s1c = t;
          end
          len = v.mode ? (1 << cur_s) : (1 << (AW - 1 - cur_s));
          g  = mj / len;
          k  = mj % len;
          ea = 2 * len * g + k;
          eb = ea + len;
          et = v.mode ? (1 << (AW - 1 - cur_s)) + g : (1 << cur_s) + g;
          if (a != ea || b != eb || tw != et) aerr++;
          if (cur_s == 0 && mj == 0) f0 = p;
          if (cur_s == AW - 1 && mj == 0) f6 = p;
          if (cur_s == AW - 1) l6 = p;
          if (t == v.shi + 1) res = p;
          mj++;
        end
        if (t >= v.slo && t <= v.shi && bif.rd_en) stl_rd++;
        if (bif.busy && bif.bf_inv != v.mode) ierr++;
        iss_en[t] = int'(bif.rd_en);
        iss_a[t]  = bif.rd_en ? a : 0;
        iss_b[t]  = bif.rd_en ? b : 0;
        if (t >= BL) begin
          if (int'(bif.wr_en) != iss_en[t-BL]) werr++;
          else if (bif.wr_en && (int'(bif.wr_addr_a) != iss_a[t-BL]
                   || int'(bif.wr_addr_b) != iss_b[t-BL])) werr++;
        end else if (bif.wr_en) begin
          werr++;
        end
        if (bif.wr_en) nwr++;
        if (bif.done) done_t = t;
      end
      chk($sformatf("v%0d_done_cycle", n), done_t, v.done);
      chk($sformatf("v%0d_busy_c1", n), b1, 1);
      chk($sformatf("v%0d_stage1_first", n), s1c, v.s1c);
      chk($sformatf("v%0d_rd_count", n), nrd, 448);
      chk($sformatf("v%0d_wr_count", n), nwr, v.nwr);
      chk($sformatf("v%0d_scl_count", n), nscl, v.nscl);
      chk($sformatf("v%0d_s0_first", n), f0, v.f0);
      chk($sformatf("v%0d_s6_first", n), f6, v.f6);
      chk($sformatf("v%0d_s6_last", n), l6, v.l6);
      chk($sformatf("v%0d_last_stage_bf", n), mj, 64);
      chk($sformatf("v%0d_addr_errs", n), aerr, 0);
      chk($sformatf("v%0d_wb_errs", n), werr, 0);
      chk($sformatf("v%0d_inv_errs", n), ierr, 0);
      chk($sformatf("v%0d_scale_errs", n), serr, 0);
      chk($sformatf("v%0d_rd_in_stall", n), stl_rd, 0);
      if (v.shi >= 0) chk($sformatf("v%0d_resume", n), res, v.res);
      @(posedge clk); #1;
      bif.start = 1'b0;
      bif.stall = 1'b0;
      bif.mode  = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_start_at_done_ignored", n), int'(bif.busy), 0);
      chk($sformatf("v%0d_done_pulse", n), int'(bif.done), 0);
    end

    busy200 = 0;
    for (int t = 0; t <= 200; t++) begin
      @(posedge clk); #1;
      bif.start = (t == 0);
      bif.mode  = 1'b1;
      bif.stall = 1'b0;
      if (t == 200) rst = 1'b0;
      @(negedge clk);
      if (t == 200) busy200 = int'(bif.busy) + int'(bif.bf_inv);
    end
    chk("abort_pre_active", busy200, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    bif.start = 1'b0;
    @(negedge clk);
    chk("abort_outs_zero", osum(), 0);
    early = 0;
    done_t = -1;
    for (int t = 202; t < 1200 && done_t < 0; t++) begin
      @(posedge clk); #1;
      bif.start = (t == 205);
      bif.mode  = 1'b0;
      @(negedge clk);
      if (t < 205 && (bif.done || bif.busy)) early++;
      if (bif.done) done_t = t;
    end
    chk("abort_no_done", early, 0);
    chk("restart_done_cycle", done_t, 205 + 477);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
